// File: rtl/sample_iterator_pkg.sv
// Shared raster definitions: iterator state encoding, subsample one-hot
// codes, default coordinate precision and a rate-to-shift helper.
package sample_iterator_pkg;

  localparam int DEF_SIGFIG = 24;
  localparam int DEF_RADIX  = 10;

  localparam logic [3:0] SS_1X  = 4'b1000;
  localparam logic [3:0] SS_4X  = 4'b0100;
  localparam logic [3:0] SS_16X = 4'b0010;
  localparam logic [3:0] SS_64X = 4'b0001;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  // Number of halvings of the unit step for a subsample rate; unknown codes act as 1x.
  function automatic int unsigned ss_shift(input logic [3:0] ss);
    case (ss)
      SS_4X:   return 1;
      SS_16X:  return 2;
      SS_64X:  return 3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/sample_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for sample jitter.
// Only present in builds with SAMPLE_JITTER_EN defined.
`ifdef SAMPLE_JITTER_EN
module sample_lfsr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  // Advance one step per enabled cycle; seed restored on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule
`endif

// File: rtl/sample_iterator.sv
// Walks a bounding box in raster order on the subsample grid, one sample
// per cycle, latching the triangle and colour for downstream tests.
// Optional build macro: SAMPLE_JITTER_EN (adds LFSR jitter below one step).
module sample_iterator
  import sample_iterator_pkg::*;
#(
  parameter int SIGFIG = DEF_SIGFIG,
  parameter int RADIX  = DEF_RADIX,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R14U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]             box_R14S,
  input  logic                                           validTri_R14H,
  input  logic        [3:0]                              subSample_RnnnnU,
  output logic                                           halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]           color_R16U,
  output logic signed [1:0][SIGFIG-1:0]                  sample_R16S,
  output logic                                           validSamp_R16H
);

  localparam int W1 = SIGFIG + 1;

  state_t                                          r_state;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   r_tri;
  logic        [COLORS-1:0][SIGFIG-1:0]            r_color;
  logic signed [SIGFIG-1:0]                        r_x, r_y;
  logic signed [SIGFIG-1:0]                        r_ll_x, r_ur_x, r_ur_y;
  logic signed [SIGFIG:0]                          r_step;

  logic signed [SIGFIG-1:0] w_ll_x, w_ll_y, w_ur_x, w_ur_y;
  logic signed [SIGFIG-1:0] w_ll_x_fl, w_ll_y_fl;
  logic        [SIGFIG:0]   w_in_step;
  logic        [SIGFIG-1:0] w_in_mask;
  logic                     w_empty;
  logic signed [SIGFIG:0]   w_nx, w_ny, w_ur_x_ext, w_ur_y_ext;
  logic                     w_last_x, w_last_y;
  logic                     w_emit;

  assign w_ll_x = box_R14S[0][0];
  assign w_ll_y = box_R14S[0][1];
  assign w_ur_x = box_R14S[1][0];
  assign w_ur_y = box_R14S[1][1];

  assign w_in_step = W1'(1) << (RADIX - ss_shift(subSample_RnnnnU));
  assign w_in_mask = w_in_step[SIGFIG-1:0] - SIGFIG'(1);
  // Clearing low bits floors toward -inf in two's complement, also for negative ll.
  assign w_ll_x_fl = w_ll_x & ~w_in_mask;
  assign w_ll_y_fl = w_ll_y & ~w_in_mask;
  assign w_empty   = (w_ur_x < w_ll_x) || (w_ur_y < w_ll_y);

  // One extra bit keeps x+step from wrapping when ur sits near the positive maximum.
  assign w_nx       = {r_x[SIGFIG-1], r_x} + r_step;
  assign w_ny       = {r_y[SIGFIG-1], r_y} + r_step;
  assign w_ur_x_ext = {r_ur_x[SIGFIG-1], r_ur_x};
  assign w_ur_y_ext = {r_ur_y[SIGFIG-1], r_ur_y};
  assign w_last_x   = w_nx > w_ur_x_ext;
  assign w_last_y   = w_ny > w_ur_y_ext;

  assign w_emit         = (r_state == TEST);
  assign halt_RnnnnL    = (r_state == WAIT);
  assign validSamp_R16H = w_emit;
  assign tri_R16S       = r_tri;
  assign color_R16U     = r_color;

  // Accept a triangle in WAIT, then step through the box in raster order in TEST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WAIT;
      r_tri   <= '0;
      r_color <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_ll_x  <= '0;
      r_ur_x  <= '0;
      r_ur_y  <= '0;
      r_step  <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          if (validTri_R14H) begin
            r_tri   <= tri_R14S;
            r_color <= color_R14U;
            if (!w_empty) begin
              r_ll_x  <= w_ll_x_fl;
              r_ur_x  <= w_ur_x;
              r_ur_y  <= w_ur_y;
              r_step  <= w_in_step;
              r_x     <= w_ll_x_fl;
              r_y     <= w_ll_y_fl;
              r_state <= TEST;
            end
          end
        end
        TEST: begin
          if (w_last_x) begin
            if (w_last_y) begin
              r_state <= WAIT;
            end else begin
              r_x <= r_ll_x;
              r_y <= w_ny[SIGFIG-1:0];
            end
          end else begin
            r_x <= w_nx[SIGFIG-1:0];
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

`ifdef SAMPLE_JITTER_EN
  logic [15:0]       w_lfsr;
  logic [SIGFIG-1:0] w_step_mask, w_jit_x, w_jit_y;

  sample_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst),
    .i_en   (w_emit),
    .o_lfsr (w_lfsr)
  );

  assign w_step_mask = r_step[SIGFIG-1:0] - SIGFIG'(1);
  // Byte-swapped LFSR for y so the two axes do not share the same offset.
  assign w_jit_x = w_emit ? (SIGFIG'(w_lfsr) & w_step_mask) : '0;
  assign w_jit_y = w_emit ? (SIGFIG'({w_lfsr[7:0], w_lfsr[15:8]}) & w_step_mask) : '0;
  assign sample_R16S[0] = r_x + w_jit_x;
  assign sample_R16S[1] = r_y + w_jit_y;
`else
  assign sample_R16S[0] = r_x;
  assign sample_R16S[1] = r_y;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator; build with SAMPLE_JITTER_EN to check
// jitter range and reset repeatability instead of exact grid points.
module tb_sample_iterator;

  localparam int SIGFIG = 24;

  logic                                    clk;
  logic                                    rst;
  logic signed [2:0][2:0][SIGFIG-1:0]      tri_in;
  logic        [2:0][SIGFIG-1:0]           color_in;
  logic signed [1:0][1:0][SIGFIG-1:0]      box;
  logic                                    valid;
  logic        [3:0]                       ss;
  logic                                    halt;
  logic signed [2:0][2:0][SIGFIG-1:0]      tri_out;
  logic        [2:0][SIGFIG-1:0]           color_out;
  logic signed [1:0][SIGFIG-1:0]           samp;
  logic                                    vsamp;

  int n_total = 0;
  int n_bad   = 0;

  sample_iterator #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R14S         (tri_in),
    .color_R14U       (color_in),
    .box_R14S         (box),
    .validTri_R14H    (valid),
    .subSample_RnnnnU (ss),
    .halt_RnnnnL      (halt),
    .tri_R16S         (tri_out),
    .color_R16U       (color_out),
    .sample_R16S      (samp),
    .validSamp_R16H   (vsamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check the visible sample against grid point (gx,gy), then move to the next negedge.
  task automatic exp_samp(input string tag, input int gx, input int gy, input int step);
    logic [SIGFIG-1:0] sx, sy;
    sx = samp[0];
    sy = samp[1];
    chk({tag, ".v"}, vsamp, 1'b1);
`ifdef SAMPLE_JITTER_EN
    chk({tag, ".xr"}, (int'(sx) >= gx && int'(sx) <= gx + step - 1), 1'b1);
    chk({tag, ".yr"}, (int'(sy) >= gy && int'(sy) <= gy + step - 1), 1'b1);
`else
    chk({tag, ".x"}, sx, SIGFIG'(gx));
    chk({tag, ".y"}, sy, SIGFIG'(gy));
    if (step < 0) chk({tag, ".s"}, 1'b0, 1'b1);
`endif
    @(negedge clk);
  endtask

  task automatic set_box(input int llx, input int lly, input int urx, input int ury);
    box[0][0] = SIGFIG'(llx);
    box[0][1] = SIGFIG'(lly);
    box[1][0] = SIGFIG'(urx);
    box[1][1] = SIGFIG'(ury);
  endtask

  // Present a triangle for one clock edge starting from a negedge.
  task automatic accept(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] rate);
    set_box(llx, lly, urx, ury);
    ss    = rate;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  logic signed [2:0][2:0][SIGFIG-1:0] tri_ref;
  logic        [2:0][SIGFIG-1:0]      color_ref;
  int gx6[6] = '{0, 1024, 2048, 0, 1024, 2048};
  int gy6[6] = '{0, 0, 0, 1024, 1024, 1024};

  initial begin
    rst   = 1'b0;
    valid = 1'b0;
    ss    = 4'b1000;
    set_box(0, 0, 0, 0);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        tri_in[v][a] = SIGFIG'(v * 16 + a + 1);
    color_in = {24'd3000, 24'd2000, 24'd1000};

    // reset state
    #12;
    chk("rst.halt", halt, 1'b1);
    chk("rst.vs", vsamp, 1'b0);
    chk("rst.samp", samp, '0);
    chk("rst.tri", tri_out, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1x box (0,0)-(2048,1024): six samples
    chk("t1.halt0", halt, 1'b1);
    tri_ref   = tri_in;
    color_ref = color_in;
    accept(0, 0, 2048, 1024, 4'b1000);
    tri_in   = '0;
    color_in = '0;
    chk("t1.halt", halt, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t1.tri", tri_out, tri_ref);
      chk("t1.col", color_out, color_ref);
      exp_samp($sformatf("t1.s%0d", i), gx6[i], gy6[i], 1024);
    end
    chk("t1.end.halt", halt, 1'b1);
    chk("t1.end.vs", vsamp, 1'b0);
    tri_in   = tri_ref;
    color_in = color_ref;

    // 4x box (0,0)-(512,0): two samples
    accept(0, 0, 512, 0, 4'b0100);
    exp_samp("t2.s0", 0, 0, 512);
    exp_samp("t2.s1", 512, 0, 512);
    chk("t2.end.halt", halt, 1'b1);
    chk("t2.end.vs", vsamp, 1'b0);

    // 4x box (700,300)-(1100,300): ll floored to (512,0)
    accept(700, 300, 1100, 300, 4'b0100);
    exp_samp("t3.s0", 512, 0, 512);
    exp_samp("t3.s1", 1024, 0, 512);
    chk("t3.end.vs", vsamp, 1'b0);

    // ll == ur: exactly one sample
    accept(1024, 1024, 1024, 1024, 4'b1000);
    exp_samp("t4.s0", 1024, 1024, 1024);
    chk("t4.end.vs", vsamp, 1'b0);

    // ur at positive maximum: increment must not wrap
    accept(8387584, 0, 8388607, 0, 4'b1000);
    exp_samp("t5.s0", 8387584, 0, 1024);
    chk("t5.end.vs", vsamp, 1'b0);
    chk("t5.end.halt", halt, 1'b1);

    // inverted box: accepted, no samples, stays in WAIT
    accept(1024, 1024, 512, 512, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      chk("t6.vs", vsamp, 1'b0);
      chk("t6.halt", halt, 1'b1);
      @(negedge clk);
    end

    // validTri held high with a new box during TEST
    set_box(0, 0, 1024, 0);
    ss    = 4'b1000;
    valid = 1'b1;
    tri_ref = tri_in;
    @(posedge clk);
    @(negedge clk);
    set_box(3072, 3072, 3072, 3072);
    tri_in = '1;
    chk("t7.tri0", tri_out, tri_ref);
    exp_samp("t7.s0", 0, 0, 1024);
    chk("t7.tri1", tri_out, tri_ref);
    exp_samp("t7.s1", 1024, 0, 1024);
    chk("t7.wait.halt", halt, 1'b1);
    chk("t7.wait.vs", vsamp, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    exp_samp("t7.s2", 3072, 3072, 1024);
    chk("t7.end.vs", vsamp, 1'b0);
    tri_in = tri_ref;

    // reset mid-iteration after the 3rd sample
    accept(0, 0, 2048, 1024, 4'b1000);
    for (int i = 0; i < 3; i++) exp_samp($sformatf("t8.s%0d", i), gx6[i], gy6[i], 1024);
    #2 rst = 1'b0;
    #1;
    chk("t8.rst.vs", vsamp, 1'b0);
    chk("t8.rst.halt", halt, 1'b1);
    chk("t8.rst.samp", samp, '0);
    chk("t8.rst.tri", tri_out, '0);
    chk("t8.rst.col", color_out, '0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t8.post.vs", vsamp, 1'b0);
      chk("t8.post.halt", halt, 1'b1);
    end

`ifdef SAMPLE_JITTER_EN
    begin
      logic [SIGFIG-1:0] rec_x[6], rec_y[6];
      for (int pass = 0; pass < 2; pass++) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        accept(0, 0, 2048, 1024, 4'b1000);
        for (int i = 0; i < 6; i++) begin
          if (pass == 0) begin
            rec_x[i] = samp[0];
            rec_y[i] = samp[1];
          end else begin
            chk("j.rep.x", samp[0], rec_x[i]);
            chk("j.rep.y", samp[1], rec_y[i]);
          end
          exp_samp($sformatf("j%0d.s%0d", pass, i), gx6[i], gy6[i], 1024);
        end
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
